// File: rtl/cmd_frame_ctrl.sv
// Command frame parser: assembles SYNC/CMD/DHI/DLO/CHK byte frames from a
// UART receiver, validates the 8-bit additive checksum, and presents the last
// good command and payload to a consumer with a ready/acknowledge handshake.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | hunting for SYNC, all other bytes discarded
// GET_CMD | waiting for the command byte
// GET_HI  | waiting for payload high byte
// GET_LO  | waiting for payload low byte
// GET_CHK | waiting for checksum byte, frame completes here
module cmd_frame_ctrl #(
  parameter logic [15:0] TO_CYCLES = 16'd65000,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  output logic        frm_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_HI  = 3'd2,
    GET_LO  = 3'd3,
    GET_CHK = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  acc;
  logic [15:0] to_cnt;
  logic [7:0]  cmd_sh, hi_sh, lo_sh;

  logic sync_hit;
  logic good_frm;
  logic bad_frm;
  logic timeout;
  logic collect;

  // State register; reset mid-frame drops the partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: advance one state per accepted byte, timeout forces IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_rdy && rx_data == SYNC) state_nxt = GET_CMD;
      GET_CMD: if (rx_rdy) state_nxt = GET_HI;
      GET_HI:  if (rx_rdy) state_nxt = GET_LO;
      GET_LO:  if (rx_rdy) state_nxt = GET_CHK;
      GET_CHK: if (rx_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  // Outputs and per-cycle event strobes; every offered byte is consumed
  always_comb begin
    clr_rx_rdy = rx_rdy;
    sync_hit   = (state == IDLE) && rx_rdy && (rx_data == SYNC);
    collect    = rx_rdy && ((state == GET_CMD) || (state == GET_HI) || (state == GET_LO));
    good_frm   = (state == GET_CHK) && rx_rdy && (rx_data == acc);
    bad_frm    = (state == GET_CHK) && rx_rdy && (rx_data != acc);
    // an accepted byte in the terminal-count cycle beats the timeout
    timeout    = (state != IDLE) && !rx_rdy && (to_cnt == TO_CYCLES - 16'd1);
  end

  // Checksum accumulator (wraps mod 256) and field shadows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 8'h00;
      cmd_sh <= 8'h00;
      hi_sh  <= 8'h00;
      lo_sh  <= 8'h00;
    end else if (sync_hit) begin
      acc <= 8'h00;
    end else if (collect) begin
      acc <= acc + rx_data;
      case (state)
        GET_CMD: cmd_sh <= rx_data;
        GET_HI:  hi_sh  <= rx_data;
        default: lo_sh  <= rx_data;
      endcase
    end
  end

  // Inter-byte timeout counter, idle in IDLE and restarted by every byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       to_cnt <= 16'd0;
    else if (state == IDLE || rx_rdy) to_cnt <= 16'd0;
    else                              to_cnt <= to_cnt + 16'd1;
  end

  // Result registers: cmd/data only change on a good frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= 8'h00;
      data    <= 16'h0000;
      cmd_rdy <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (good_frm) begin
        cmd     <= cmd_sh;
        data    <= {hi_sh, lo_sh};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      if (sync_hit)                frm_err <= 1'b0;
      else if (bad_frm || timeout) frm_err <= 1'b1;
    end
  end

endmodule
